// File: rtl/line_window_buffer_if.sv
// Handshake bundle for line_window_buffer: pixel stream in, KSIZE x KSIZE window out.
// in_sof exists only when WINBUF_SOF_EN is defined.
interface line_window_buffer_if #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int KSIZE = 3
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    logic                         in_valid;
    logic                         in_ready;
    logic [PIX_W-1:0]             in_pixel;
`ifdef WINBUF_SOF_EN
    logic                         in_sof;
`endif
    logic                         win_valid;
    logic                         win_ready;
    logic [KSIZE*KSIZE*PIX_W-1:0] win_out;
    logic [RW-1:0]                win_row;
    logic [CW-1:0]                win_col;
    logic                         frame_done;

`ifdef WINBUF_SOF_EN
    modport master (output in_valid, in_pixel, in_sof, win_ready,
                    input  in_ready, win_valid, win_out, win_row, win_col, frame_done);
    modport slave  (input  in_valid, in_pixel, in_sof, win_ready,
                    output in_ready, win_valid, win_out, win_row, win_col, frame_done);
`else
    modport master (output in_valid, in_pixel, win_ready,
                    input  in_ready, win_valid, win_out, win_row, win_col, frame_done);
    modport slave  (input  in_valid, in_pixel, win_ready,
                    output in_ready, win_valid, win_out, win_row, win_col, frame_done);
`endif
endinterface

// File: rtl/line_window_buffer.sv
// Streaming KSIZE x KSIZE window generator over a raster pixel stream, KSIZE-1 line memories.
// Define WINBUF_SOF_EN to honour in_sof as a forced resync to pixel (0,0).
module line_window_buffer #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int KSIZE = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    line_window_buffer_if.slave   bus
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int NL = KSIZE - 1;
    localparam int LW = (NL > 1) ? $clog2(NL) : 1;
    localparam int WW = KSIZE * KSIZE * PIX_W;

    localparam logic [CW-1:0] LAST_COL   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(IMG_H - 1);
    localparam logic [RW-1:0] FILL_ROW   = RW'(KSIZE - 2);
    localparam logic [CW-1:0] FIRST_WCOL = CW'(KSIZE - 1);
    localparam logic [LW-1:0] LAST_LINE  = LW'(NL - 1);

    typedef enum logic {FILL, STREAM} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] col_cnt, eff_col;
    logic [RW-1:0] row_cnt, eff_row;
    logic [LW-1:0] wr_line;
    logic          accept, sof, line_end, frame_end, win_en;

    logic [PIX_W-1:0] lmem [NL][IMG_W];

    logic [KSIZE-1:0][PIX_W-1:0]             new_col;
    logic [KSIZE-2:0][KSIZE-1:0][PIX_W-1:0]  hist;     // [c][r], last KSIZE-1 columns seen
    logic [KSIZE-1:0][KSIZE-1:0][PIX_W-1:0]  win_nxt;  // [c][r]
    logic [WW-1:0]                           win_flat;

    // wr_line is the oldest line; the ring advances one line per completed row
    function automatic logic [LW-1:0] ring_idx(input logic [LW-1:0] base, input int r);
        int s;
        s = int'(base) + r;
        if (s >= NL) s = s - NL;
        return LW'(s);
    endfunction

    assign bus.in_ready = !bus.win_valid || bus.win_ready;
    assign accept       = bus.in_valid && bus.in_ready;
`ifdef WINBUF_SOF_EN
    assign sof = bus.in_sof;
`else
    assign sof = 1'b0;
`endif
    assign eff_col   = sof ? '0 : col_cnt;
    assign eff_row   = sof ? '0 : row_cnt;
    assign line_end  = (eff_col == LAST_COL);
    assign frame_end = line_end && (eff_row == LAST_ROW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FILL;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (frame_end || sof)
                state_nxt = FILL;
            else if (line_end && eff_row == FILL_ROW)
                state_nxt = STREAM;
        end
    end

    always_comb begin
        win_en = 1'b0;
        if (state == STREAM && !sof && eff_col >= FIRST_WCOL)
            win_en = 1'b1;
    end

    always_comb begin
        new_col = '0;
        for (int r = 0; r < NL; r++)
            new_col[r] = lmem[ring_idx(wr_line, r)][eff_col];
        new_col[KSIZE-1] = bus.in_pixel;
    end

    always_comb begin
        win_nxt = '0;
        for (int c = 0; c < KSIZE-1; c++)
            win_nxt[c] = hist[c];
        win_nxt[KSIZE-1] = new_col;
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < KSIZE; r++)
            for (int c = 0; c < KSIZE; c++)
                win_flat[PIX_W*(r*KSIZE+c) +: PIX_W] = win_nxt[c][r];
    end

    // Line memory is deliberately not reset
    always_ff @(posedge clk) begin
        if (accept)
            lmem[wr_line][eff_col] <= bus.in_pixel;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_cnt        <= '0;
            row_cnt        <= '0;
            wr_line        <= '0;
            hist           <= '0;
            bus.win_valid  <= 1'b0;
            bus.win_out    <= '0;
            bus.win_row    <= '0;
            bus.win_col    <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= accept && frame_end;
            if (accept) begin
                for (int c = 0; c < KSIZE-1; c++)
                    hist[c] <= win_nxt[c+1];
                if (line_end) begin
                    col_cnt <= '0;
                    row_cnt <= (eff_row == LAST_ROW) ? '0 : eff_row + RW'(1);
                    wr_line <= (wr_line == LAST_LINE) ? '0 : wr_line + LW'(1);
                end else begin
                    col_cnt <= eff_col + CW'(1);
                    row_cnt <= eff_row;
                end
            end
            if (accept && win_en) begin
                bus.win_valid <= 1'b1;
                bus.win_out   <= win_flat;
                bus.win_row   <= eff_row;
                bus.win_col   <= eff_col;
            end else if (bus.win_ready) begin
                bus.win_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer at IMG 4x4, KSIZE 3: vector table, hand corner cases,
// and random traffic against an image-array reference model.
module tb_line_window_buffer;
    localparam int PW = 8, IW = 4, IH = 4, K = 3;
    localparam int WW = K*K*PW;

    logic clk, reset;
    line_window_buffer_if #(.PIX_W(PW), .IMG_W(IW), .IMG_H(IH), .KSIZE(K)) bus();

    line_window_buffer #(.PIX_W(PW), .IMG_W(IW), .IMG_H(IH), .KSIZE(K)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    bit drv_sof;
`ifdef WINBUF_SOF_EN
    assign bus.in_sof = drv_sof;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0, n_fail = 0;
    int n_win = 0, n_fd = 0;

    task automatic chk(input string nm, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // ---------------- reference model: whole image kept as a 2D array ----------------
    typedef struct { logic [WW-1:0] win; int r; int c; } exp_t;
    exp_t        expq[$];
    logic [PW-1:0] img [IH][IW];
    int          pos = 0;
    bit          fd_exp = 0;

    function automatic logic [WW-1:0] model_win(input int r, input int c);
        logic [WW-1:0] w;
        w = '0;
        for (int a = 0; a < K; a++)
            for (int b = 0; b < K; b++)
                w[PW*(a*K+b) +: PW] = img[r-K+1+a][c-K+1+b];
        return w;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            expq.delete();
            pos    = 0;
            fd_exp = 0;
        end else begin
            chk("frame_done", {71'd0, bus.frame_done}, {71'd0, fd_exp});
            if (bus.frame_done) n_fd++;
            if (bus.win_valid) begin
                if (expq.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL spurious_window: got row %0d col %0d want none", bus.win_row, bus.win_col);
                end else begin
                    chk("m_win", bus.win_out, expq[0].win);
                    chk("m_row", WW'(bus.win_row), WW'(expq[0].r));
                    chk("m_col", WW'(bus.win_col), WW'(expq[0].c));
                    if (bus.win_ready) begin
                        void'(expq.pop_front());
                        n_win++;
                    end
                end
            end
            fd_exp = 0;
            if (bus.in_valid && bus.in_ready) begin
                int r, c;
                if (drv_sof) pos = 0;
                r = pos / IW;
                c = pos % IW;
                img[r][c] = bus.in_pixel;
                if (r >= K-1 && c >= K-1) expq.push_back('{model_win(r, c), r, c});
                fd_exp = (pos == IW*IH-1);
                pos = (pos + 1) % (IW*IH);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [PW-1:0] pix, input bit sof);
        bit acc;
        int guard;
        bus.in_valid = 1'b1;
        bus.in_pixel = pix;
        drv_sof      = sof;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            guard++;
        end
        n_cmp++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_timeout: pixel %0d not accepted in 200 cycles", pix);
        end
        bus.in_valid = 1'b0;
        drv_sof      = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_valid", WW'(bus.win_valid), '0);
        chk("rst_win",   bus.win_out, '0);
        chk("rst_row",   WW'(bus.win_row), '0);
        chk("rst_col",   WW'(bus.win_col), '0);
        chk("rst_fdone", WW'(bus.frame_done), '0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", WW'(bus.in_ready), WW'(1));
    endtask

    task automatic send_frame(input int gap_pct);
        for (int i = 0; i < IW*IH; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                @(posedge clk); #1;
            end
            send(PW'(4*(i/IW) + i%IW), 1'b0);
        end
    endtask

    task automatic settle();
        bus.win_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("queue_empty", WW'(expq.size()), '0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [PW-1:0] pix;
        logic          exp_v;
        int            exp_r, exp_c;
        logic [WW-1:0] exp_win;
    } vec_t;
    vec_t tbl[IW*IH];

    function automatic logic [WW-1:0] formula_win(input int r, input int c);
        logic [WW-1:0] w;
        w = '0;
        for (int a = 0; a < K; a++)
            for (int b = 0; b < K; b++)
                w[PW*(a*K+b) +: PW] = PW'(4*(r-K+1+a) + (c-K+1+b));
        return w;
    endfunction

    int w0, f0;
    logic [WW-1:0] first_win;

    initial begin
        for (int i = 0; i < IW*IH; i++) begin
            tbl[i].pix     = PW'(4*(i/IW) + i%IW);
            tbl[i].exp_v   = (i/IW >= K-1) && (i%IW >= K-1);
            tbl[i].exp_r   = i/IW;
            tbl[i].exp_c   = i%IW;
            tbl[i].exp_win = tbl[i].exp_v ? formula_win(i/IW, i%IW) : '0;
        end
        first_win = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};

        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        bus.win_ready = 1'b1;
        drv_sof = 1'b0;
        do_reset();

        // 1: one frame, window after each accept
        w0 = n_win; f0 = n_fd;
        for (int i = 0; i < IW*IH; i++) begin
            send(tbl[i].pix, 1'b0);
            chk("t_valid", WW'(bus.win_valid), WW'(tbl[i].exp_v));
            if (tbl[i].exp_v) begin
                chk("t_win", bus.win_out, tbl[i].exp_win);
                chk("t_row", WW'(bus.win_row), WW'(tbl[i].exp_r));
                chk("t_col", WW'(bus.win_col), WW'(tbl[i].exp_c));
            end
            if (i == 2*IW + 2) chk("t_first_win", bus.win_out, first_win);
        end
        chk("t_fdone_hi", WW'(bus.frame_done), WW'(1));
        @(posedge clk); #1;
        chk("t_fdone_lo", WW'(bus.frame_done), '0);
        settle();
        chk("s1_windows", WW'(n_win - w0), WW'(4));
        chk("s1_fdone",   WW'(n_fd - f0),  WW'(1));

        // 2: two back-to-back frames
        w0 = n_win; f0 = n_fd;
        send_frame(0);
        send_frame(0);
        settle();
        chk("s2_windows", WW'(n_win - w0), WW'(8));
        chk("s2_fdone",   WW'(n_fd - f0),  WW'(2));

        // 3: stall with (2,2) pending, then release
        do_reset();
        w0 = n_win;
        bus.win_ready = 1'b0;
        for (int i = 0; i <= 2*IW + 2; i++) send(tbl[i].pix, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_pixel = tbl[11].pix;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_ready", WW'(bus.in_ready), '0);
            chk("stall_win",   bus.win_out, tbl[10].exp_win);
        end
        bus.win_ready = 1'b1;
        for (int i = 11; i < IW*IH; i++) send(tbl[i].pix, 1'b0);
        settle();
        chk("s3_windows", WW'(n_win - w0), WW'(4));

        // 4: random input gaps
        w0 = n_win;
        send_frame(50);
        settle();
        chk("s4_windows", WW'(n_win - w0), WW'(4));

        // 5: reset after 9 pixels, then a full frame
        for (int i = 0; i < 9; i++) send(tbl[i].pix, 1'b0);
        do_reset();
        w0 = n_win; f0 = n_fd;
        send_frame(0);
        settle();
        chk("s5_windows", WW'(n_win - w0), WW'(4));
        chk("s5_fdone",   WW'(n_fd - f0),  WW'(1));

`ifdef WINBUF_SOF_EN
        // 6: truncated frame then in_sof resync
        w0 = n_win; f0 = n_fd;
        for (int i = 0; i < 6; i++) send(tbl[i].pix, 1'b0);
        send(tbl[0].pix, 1'b1);
        for (int i = 1; i < IW*IH; i++) send(tbl[i].pix, 1'b0);
        settle();
        chk("s6_windows", WW'(n_win - w0), WW'(4));
        chk("s6_fdone",   WW'(n_fd - f0),  WW'(1));
`endif

        // random pixels, random gaps, random backpressure
        w0 = n_win;
        fork
            begin
                for (int f = 0; f < 3; f++)
                    for (int i = 0; i < IW*IH; i++) begin
                        if ($urandom_range(1) == 0) begin @(posedge clk); #1; end
                        send(PW'($urandom), 1'b0);
                    end
            end
            begin
                for (int n = 0; n < 400; n++) begin
                    @(posedge clk); #1;
                    bus.win_ready = ($urandom_range(2) != 0);
                end
            end
        join
        settle();
        chk("rnd_windows", WW'(n_win - w0), WW'(12));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end
endmodule
